// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Multi-cycle data-memory target for the Memory stage. Accepts
//             one load/store request at a time over a valid/ready handshake,
//             inserts WAIT_CYCLES wait states, commits byte-lane writes or
//             captures read data on the edge entering RESP, and returns a
//             single-cycle response pulse with an error flag. Holds the
//             pipeline via stall while a request is pending.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DAT_WIDTH   = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DAT_WIDTH-1:0]  wdata,
  input  logic [3:0]            wstrb,
  output logic [DAT_WIDTH-1:0]  rdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic                  stall
);

  // Word-index width; byte address bits [c_IDX_W+1:2] select the word.
  localparam int c_IDX_W = $clog2(DEPTH_WORDS);

  // Counter reload value: WAIT entry already consumes one edge.
  localparam logic [3:0] c_WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
  localparam bit         c_ZERO_WAIT = (WAIT_CYCLES == 0);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DAT_WIDTH-1:0]  r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_rd;
  logic                  r_wr;
  logic [DAT_WIDTH-1:0]  r_rdata;
  logic [DAT_WIDTH-1:0]  r_mem [DEPTH_WORDS];

  logic                  w_idle;
  logic                  w_op;
  logic                  w_accept;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DAT_WIDTH-1:0]  w_sel_wdata;
  logic [3:0]            w_sel_wstrb;
  logic                  w_sel_rd;
  logic                  w_sel_wr;
  logic                  w_misalign;
  logic                  w_out_of_range;
  logic                  w_both;
  logic                  w_err;
  logic [c_IDX_W-1:0]    w_idx;

  assign w_idle   = (r_state == c_ST_IDLE);
  assign w_op     = MemRead | MemWrite;
  assign w_accept = w_idle & req_valid & w_op;

  // In IDLE the live request is examined (the zero-wait commit happens on
  // the acceptance edge); everywhere else the latched request is used so
  // the inputs are free to change while the access is in flight.
  assign w_sel_addr  = w_idle ? addr     : r_addr;
  assign w_sel_wdata = w_idle ? wdata    : r_wdata;
  assign w_sel_wstrb = w_idle ? wstrb    : r_wstrb;
  assign w_sel_rd    = w_idle ? MemRead  : r_rd;
  assign w_sel_wr    = w_idle ? MemWrite : r_wr;

  // Error classification: full-word alignment, range and opcode sanity.
  assign w_misalign     = (w_sel_addr[1:0] != 2'b00);
  assign w_out_of_range = ((w_sel_addr >> (c_IDX_W + 2)) != '0);
  assign w_both         = w_sel_rd & w_sel_wr;
  assign w_err          = w_misalign | w_out_of_range | w_both;
  assign w_idx          = w_sel_addr[c_IDX_W+1:2];

  // The commit edge is the one entering RESP.
  generate
    if (c_ZERO_WAIT) begin : g_zero_wait
      assign w_commit = w_accept;
    end else begin : g_with_wait
      assign w_commit = (r_state == c_ST_WAIT) && (r_cnt == 4'd0);
    end
  endgenerate

  // Request FSM: latch on acceptance, count wait states, one RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            r_rd    <= MemRead;
            r_wr    <= MemWrite;
            if (c_ZERO_WAIT) begin
              r_state <= c_ST_RESP;
            end else begin
              r_state <= c_ST_WAIT;
              r_cnt   <= c_WAIT_LOAD;
            end
          end
        end
        c_ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= c_ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_ST_RESP: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Read data capture on commit; writes and errors return zero, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_commit) begin
      if (w_sel_rd && !w_err) begin
        r_rdata <= r_mem[w_idx];
      end else begin
        r_rdata <= '0;
      end
    end
  end

  // Storage: byte-lane write on commit for error-free stores; not reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_sel_wr && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_sel_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_sel_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = (r_state == c_ST_RESP);
  assign resp_err   = resp_valid & w_err;
  assign rdata      = r_rdata;
  // RESP deliberately drops stall so the pipeline advances as RESP ends.
  assign stall      = w_accept | (r_state == c_ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Self-checking bench for dmem_responder. Three instances with
//             WAIT_CYCLES = 2, 0 and 3; expected responses are queued when a
//             request is accepted and compared when resp_valid pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int N = 3;

  function automatic int wc(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [N];
  logic        req_valid  [N];
  logic        mem_read   [N];
  logic        mem_write  [N];
  logic [31:0] addr       [N];
  logic [31:0] wdata      [N];
  logic [3:0]  wstrb      [N];
  logic        req_ready  [N];
  logic [31:0] rdata      [N];
  logic        resp_valid [N];
  logic        resp_err   [N];
  logic        stall      [N];

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      dmem_responder #(
        .ADDR_WIDTH (32),
        .DAT_WIDTH  (32),
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(wc(g))
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n[g]),
        .req_valid (req_valid[g]),
        .req_ready (req_ready[g]),
        .MemRead   (mem_read[g]),
        .MemWrite  (mem_write[g]),
        .addr      (addr[g]),
        .wdata     (wdata[g]),
        .wstrb     (wstrb[g]),
        .rdata     (rdata[g]),
        .resp_valid(resp_valid[g]),
        .resp_err  (resp_err[g]),
        .stall     (stall[g])
      );
    end
  endgenerate

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          inst;
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   stall_cnt [N] = '{0, 0, 0};

  // Response monitor and stall counter, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (stall[k] === 1'b1) stall_cnt[k]++;
      if (resp_valid[k] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check($sformatf("spurious_resp%0d", k), 32'(resp_valid[k]), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_inst",      k,                   e.inst);
          check("resp_cycle",     cyc,                 e.cyc);
          check("resp_err",       32'(resp_err[k]),    32'(e.err));
          check("resp_rdata",     rdata[k],            e.data);
          check("resp_ready_low", 32'(req_ready[k]),   32'd0);
          check("resp_stall_low", 32'(stall[k]),       32'd0);
        end
      end
    end
  end

  // Present one request, wait for acceptance, queue its expected response.
  task automatic issue(input int k, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic e_err, input logic [31:0] e_data, input bit push,
                       output int acc);
    int   n;
    exp_t e;
    req_valid[k] = 1'b1;
    mem_read[k]  = rd;
    mem_write[k] = wr;
    addr[k]      = a;
    wdata[k]     = d;
    wstrb[k]     = s;
    n = 0;
    @(negedge clk);
    while (req_ready[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready",    32'(req_ready[k]), 32'd1);
    check("stall_on_req", 32'(stall[k]),     32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) begin
      e.inst = k;
      e.cyc  = cyc + wc(k);
      e.err  = e_err;
      e.data = e_data;
      sb_q.push_back(e);
    end
    req_valid[k] = 1'b0;
    mem_read[k]  = 1'($urandom_range(0, 1));
    mem_write[k] = 1'($urandom_range(0, 1));
    addr[k]      = $urandom;
    wdata[k]     = $urandom;
    wstrb[k]     = 4'($urandom);
  endtask

  // Wait until every queued response has been seen, then return to IDLE.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("drain_timeout", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, s0;
    for (int k = 0; k < N; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b0;
      mem_read[k]  = 1'b0;
      mem_write[k] = 1'b0;
      addr[k]      = '0;
      wdata[k]     = '0;
      wstrb[k]     = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      check("rst_req_ready",  32'(req_ready[k]),  32'd1);
      check("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      check("rst_resp_err",   32'(resp_err[k]),   32'd0);
      check("rst_rdata",      rdata[k],           32'd0);
      check("rst_stall",      32'(stall[k]),      32'd0);
      rst_n[k] = 1'b1;
    end
    @(posedge clk);
    #1;

    // ---- Instance 0: WAIT_CYCLES = 2 ----
    s0 = stall_cnt[0];
    issue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b1, a0);
    drain();
    check("stall_cycles_wr", stall_cnt[0] - s0, 3);
    s0 = stall_cnt[0];
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1, a0);
    drain();
    check("stall_cycles_rd", stall_cnt[0] - s0, 3);
    issue(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'h5, 1'b0, 32'h0, 1'b1, a0);
    drain();
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b1, a0);
    drain();
    issue(0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 1'b1, a0);
    drain();
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b1, a0);
    drain();
    issue(0, 1'b1, 1'b0, 32'h12, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, a0);
    drain();
    issue(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, a0);
    drain();
    issue(0, 1'b0, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b1, a0);
    drain();
    issue(0, 1'b1, 1'b1, 32'h14, 32'h12345678, 4'hF, 1'b1, 32'h0, 1'b1, a0);
    drain();
    issue(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b1, a0);
    drain();

    // Request with no operation must be ignored entirely.
    req_valid[0] = 1'b1;
    mem_read[0]  = 1'b0;
    mem_write[0] = 1'b0;
    addr[0]      = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("noop_stall", 32'(stall[0]),     32'd0);
      check("noop_ready", 32'(req_ready[0]), 32'd1);
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // ---- Instance 1: WAIT_CYCLES = 0 ----
    issue(1, 1'b0, 1'b1, 32'h0, 32'h01020304, 4'hF, 1'b0, 32'h0, 1'b1, a0);
    drain();
    issue(1, 1'b0, 1'b1, 32'h4, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, 1'b1, a0);
    drain();
    s0 = stall_cnt[1];
    issue(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h01020304, 1'b1, a0);
    issue(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5, 1'b1, a1);
    drain();
    check("b2b_spacing",      a1 - a0,             2);
    check("b2b_stall_cycles", stall_cnt[1] - s0,   2);

    // ---- Instance 2: WAIT_CYCLES = 3, reset during WAIT ----
    issue(2, 1'b0, 1'b1, 32'h20, 32'h55555555, 4'hF, 1'b0, 32'h0, 1'b1, a0);
    drain();
    issue(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h55555555, 1'b1, a0);
    drain();
    issue(2, 1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, 1'b0, 32'h0, 1'b0, a0);
    @(posedge clk);
    #1;
    rst_n[2] = 1'b0;
    #1;
    check("midrst_req_ready",  32'(req_ready[2]),  32'd1);
    check("midrst_resp_valid", 32'(resp_valid[2]), 32'd0);
    check("midrst_resp_err",   32'(resp_err[2]),   32'd0);
    check("midrst_rdata",      rdata[2],           32'd0);
    check("midrst_stall",      32'(stall[2]),      32'd0);
    @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h55555555, 1'b1, a0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder; the target end of the Memory stage's load/store interface.
- Replaces the single-cycle data memory and adds request/response handshake, byte-lane writes, configurable wait states and error reporting.
- Drives a stall to the pipeline while a request is outstanding.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DAT_WIDTH, 32, data word width. Fixed at 32; wstrb is 4 bits.
- DEPTH_WORDS, 1024, number of words in storage. Power of two, at least 2.
- WAIT_CYCLES, 2, extra cycles between acceptance and response. Range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present (MemRead or MemWrite phase of the Memory stage).
- req_ready  output  1  responder can accept a request; high only in IDLE.
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- addr  input  ADDR_WIDTH  byte address (ALU result).
- wdata  input  DAT_WIDTH  store data.
- wstrb  input  4  store byte enables; bit i enables wdata[8i+7:8i].
- rdata  output  DAT_WIDTH  load data, valid while resp_valid is high.
- resp_valid  output  1  single-cycle response pulse.
- resp_err  output  1  error flag, meaningful only while resp_valid is high.
- stall  output  1  hold the Memory stage and everything upstream of it.

Behaviour:
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, rdata=0, wait counter=0. Storage contents are not reset.
- Reset asserted mid-operation aborts the request. A write whose commit edge has not occurred is never committed.
- Acceptance edge E0: req_valid & req_ready at a rising edge.
  - Latch addr, wdata, wstrb, MemRead, MemWrite.
  - req_valid with neither MemRead nor MemWrite is ignored: no acceptance, stall=0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE to WAIT on acceptance if WAIT_CYCLES>0; counter loads WAIT_CYCLES-1.
  - IDLE to RESP on acceptance if WAIT_CYCLES=0.
  - WAIT decrements the counter each edge and goes to RESP on the edge where the counter is 0.
  - RESP to IDLE unconditionally after one cycle.
- Latency: resp_valid is high exactly for the cycle between edges E0+WAIT_CYCLES and E0+WAIT_CYCLES+1.
- Throughput: at most one request per WAIT_CYCLES+2 cycles, because req_ready=0 in WAIT and RESP.
- Commit edge: the edge entering RESP.
  - Writes update enabled byte lanes on this edge.
  - Reads register the full word into rdata on this edge.
  - For writes, rdata=0 during the response.
  - rdata holds its value outside RESP.
- Word index: addr[log2(DEPTH_WORDS)+1:2].
- Errors (resp_err=1, no storage change, rdata=0):
  - addr[1:0] != 0, i.e. misaligned. Full-word accesses only.
  - any addr bit above log2(DEPTH_WORDS)+1 set, i.e. out of range.
  - MemRead and MemWrite both high at acceptance.
- A write with wstrb=0 is legal: no change, resp_err=0.
- Read-after-write: a request accepted after a write's RESP cycle observes the new data.
- stall = (state==IDLE & req_valid & (MemRead|MemWrite)) | (state==WAIT). stall=0 in RESP so the pipeline advances on the edge ending RESP.
- Request inputs may change while not in IDLE; they are ignored there.

Test Plan:
- WAIT_CYCLES=2: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then read 0x10.
  - Write: resp_valid in the 3rd cycle after acceptance, resp_err=0.
  - Read: rdata=0xDEADBEEF, stall high for exactly 3 cycles per request.
- Byte lanes: after 0xDEADBEEF at 0x10, write 0x11223344 with wstrb 0x5, then read → rdata=0xDE22BE44.
- Errors:
  - read addr 0x12 → resp_err=1, rdata=0.
  - read addr 0x1000 with DEPTH_WORDS=1024 → resp_err=1.
  - write 0x14 with MemRead=MemWrite=1 → resp_err=1; a subsequent read of 0x14 returns the prior contents unchanged.
- WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4.
  - Each resp_valid appears the cycle after its acceptance; req_ready=0 in RESP.
  - Second acceptance occurs 2 cycles after the first.
- Reset mid-WAIT: WAIT_CYCLES=3, write 0xAAAAAAAA to 0x20 over prior 0x55555555; pulse rst_n low one cycle after acceptance.
  - All outputs return to reset values immediately; no resp_valid.
  - A re-read of 0x20 returns 0x55555555.
- Idle request: req_valid=1 with MemRead=MemWrite=0 → stall=0, req_ready stays 1, no resp_valid.
